// File: rtl/qc_circular_shifter_z.sv
// ---------------------------------------------------------------------------
// qc_circular_shifter_z
//
// Pipelined Z-wrapped cyclic shifter for the QC-LDPC datapath. It rotates
// the low z_size bits of a MAXZ-bit word by shift_val, either right (dir=0)
// or left (dir=1). Output bits at or above z_size are zero. Input bits at or
// above z_size are ignored.
//
// Pipeline: one input register, then $clog2(MAXZ) barrel levels with a
// register after every PIPE_STAGES_PER_CYCLE levels. Each stage carries its
// own valid bit. All stages advance together when the output is empty or
// being taken. Bubbles are not collapsed.
//
// Ports:
//   CLK        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   block accepts input this cycle (combinational)
//   in_data    input word, bits [z_size-1:0] significant
//   z_size     active lifting size, legal 1..MAXZ
//   shift_val  rotation amount, legal 0..z_size-1
//   dir        0 = rotate right, 1 = rotate left
//   out_valid  output word valid
//   out_ready  downstream accepts output
//   out_data   rotated word
//   err        (QCS_RANGE_CHECK_EN only) word had an illegal z_size/shift_val
//
// Optional feature macro: QCS_RANGE_CHECK_EN. When defined, illegal words
// are flagged on err and passed through masked but unrotated.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module qc_circular_shifter_z #(
    parameter int MAXZ                  = 8,
    parameter int PIPE_STAGES_PER_CYCLE = 2,
    parameter int ZW                    = $clog2(MAXZ + 1),
    parameter int SW                    = $clog2(MAXZ)
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [MAXZ-1:0] in_data,
    input  logic [ZW-1:0]   z_size,
    input  logic [SW-1:0]   shift_val,
    input  logic            dir,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [MAXZ-1:0] out_data
`ifdef QCS_RANGE_CHECK_EN
    ,
    output logic            err
`endif
);

    localparam int NSTG = SW;
    localparam int NREG = (NSTG + PIPE_STAGES_PER_CYCLE - 1) / PIPE_STAGES_PER_CYCLE;

    // Bits [z-1:0] set; all ones once z reaches MAXZ.
    function automatic logic [MAXZ-1:0] zmask(input logic [ZW-1:0] z);
        logic [MAXZ-1:0] m;
        m = '0;
        for (int i = 0; i < MAXZ; i++) begin
            m[i] = (ZW'(i) < z);
        end
        return m;
    endfunction

    // Rotate right by 2**k within the low z bits. The plain right shift
    // covers bits that do not wrap; the left shift by z-2**k moves the low
    // bits that fall off the bottom up to the top of the z-bit window.
    // Relies on bits >= z of d already being zero.
    function automatic logic [MAXZ-1:0] zrot(input logic [MAXZ-1:0] d,
                                             input logic [ZW-1:0]   z,
                                             input int              k);
        logic [MAXZ-1:0] wrap;
        int              amt;
        int              wamt;
        amt  = 1 << k;
        wamt = int'(z) - amt;
        wrap = (wamt >= 0 && wamt < MAXZ) ? (d << wamt) : '0;
        return ((d >> amt) | wrap) & zmask(z);
    endfunction

    logic            st_valid [0:NREG];
    logic [MAXZ-1:0] st_data  [0:NREG];
    logic [ZW-1:0]   st_z     [0:NREG-1];
    logic [SW-1:0]   st_s     [0:NREG-1];
    logic [MAXZ-1:0] rot_d    [1:NREG];

    logic            advance;
    logic [SW-1:0]   s_right;
    logic [SW-1:0]   s_eff;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = st_valid[NREG];
    assign out_data  = st_data[NREG];

    // Left rotation by s equals right rotation by z-s; s=0 must stay 0.
    always_comb begin
        s_right = shift_val;
        if (dir && (shift_val != '0)) begin
            s_right = SW'(z_size - ZW'(shift_val));
        end
    end

`ifdef QCS_RANGE_CHECK_EN
    logic range_err;
    logic st_err [0:NREG];

    assign range_err = (z_size == '0) || (z_size > ZW'(MAXZ)) ||
                       (ZW'(shift_val) >= z_size);
    // A zero rotation turns every barrel level into a pass-through, leaving
    // the masked input on the output.
    assign s_eff = range_err ? '0 : s_right;
    assign err   = st_err[NREG];
`else
    assign s_eff = s_right;
`endif

    // Barrel levels between register stages: stage r applies levels
    // (r-1)*P .. r*P-1, each gated by its bit of the remaining shift.
    always_comb begin
        for (int r = 1; r <= NREG; r++) begin
            rot_d[r] = st_data[r-1];
            for (int l = 0; l < PIPE_STAGES_PER_CYCLE; l++) begin
                if ((r - 1) * PIPE_STAGES_PER_CYCLE + l < NSTG) begin
                    if ((st_s[r-1] & (SW'(1) << ((r - 1) * PIPE_STAGES_PER_CYCLE + l))) != '0) begin
                        rot_d[r] = zrot(rot_d[r], st_z[r-1],
                                        (r - 1) * PIPE_STAGES_PER_CYCLE + l);
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r <= NREG; r++) begin
                st_valid[r] <= 1'b0;
                st_data[r]  <= '0;
            end
            for (int r = 0; r < NREG; r++) begin
                st_z[r] <= '0;
                st_s[r] <= '0;
            end
        end else if (advance) begin
            st_valid[0] <= in_valid;
            st_data[0]  <= in_data & zmask(z_size);
            st_z[0]     <= z_size;
            st_s[0]     <= s_eff;
            for (int r = 1; r <= NREG; r++) begin
                st_valid[r] <= st_valid[r-1];
                st_data[r]  <= rot_d[r];
            end
            for (int r = 1; r < NREG; r++) begin
                st_z[r] <= st_z[r-1];
                st_s[r] <= st_s[r-1];
            end
        end
    end

`ifdef QCS_RANGE_CHECK_EN
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r <= NREG; r++) begin
                st_err[r] <= 1'b0;
            end
        end else if (advance) begin
            st_err[0] <= range_err;
            for (int r = 1; r <= NREG; r++) begin
                st_err[r] <= st_err[r-1];
            end
        end
    end
`endif

endmodule

// File: tb/tb_qc_circular_shifter_z.sv
`timescale 1ns/1ps

module tb_qc_circular_shifter_z;

    localparam int MAXZ = 8;
    localparam int ZW   = 4;
    localparam int SW   = 3;
    localparam int LAT  = 3;

    typedef struct {
        logic [7:0] d;
        logic [3:0] z;
        logic [2:0] s;
        logic       dr;
    } vec_t;

    logic            CLK = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [MAXZ-1:0] in_data;
    logic [ZW-1:0]   z_size;
    logic [SW-1:0]   shift_val;
    logic            dir;
    logic            out_valid;
    logic            out_ready;
    logic [MAXZ-1:0] out_data;
`ifdef QCS_RANGE_CHECK_EN
    logic            err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    qc_circular_shifter_z #(
        .MAXZ(MAXZ),
        .PIPE_STAGES_PER_CYCLE(2)
    ) dut (
        .CLK(CLK),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .z_size(z_size),
        .shift_val(shift_val),
        .dir(dir),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data)
`ifdef QCS_RANGE_CHECK_EN
        ,
        .err(err)
`endif
    );

    // Arithmetic reference: index-based rotation of the low z bits.
    function automatic logic [7:0] ref_rot(input logic [7:0] d, input int z,
                                           input int s, input logic dr);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < z; i++) begin
            r[i] = dr ? d[(i - s + z) % z] : d[(i + s) % z];
        end
        return r;
    endfunction

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // Sends one word with out_ready=1 on an idle pipeline and waits for the
    // output; lat is the number of rising edges from acceptance, -1 on timeout.
    task automatic send_one(input logic [7:0] d, input logic [3:0] z,
                            input logic [2:0] s, input logic dr,
                            output logic [7:0] od, output int lat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        z_size    = z;
        shift_val = s;
        dir       = dr;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge CLK);
            lat++;
        end
        od = out_data;
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        z_size    = 4'd8;
        shift_val = '0;
        dir       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_out_data got %h want 00", out_data);
        end
        rst_n = 1'b1;
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
`ifdef QCS_RANGE_CHECK_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b want 0", err);
        end
`endif
    endtask

    task automatic test_latency;
        logic [7:0] od;
        int         lat;
        idle(4);
        send_one(8'b10110101, 4'd8, 3'd3, 1'b0, od, lat);
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL latency got %0d want %0d", lat, LAT);
        end
        checks++;
        if (od !== 8'b10110110) begin
            errors++;
            $display("FAIL z8_right3 got %b want 10110110", od);
        end
    endtask

    task automatic test_directed;
        logic [7:0] od;
        int         lat;
        idle(4);
        send_one(8'b11110101, 4'd5, 3'd2, 1'b0, od, lat);
        checks++;
        if (lat != LAT || od !== 8'b00001101) begin
            errors++;
            $display("FAIL z5_right2 got %b lat %0d want 00001101 lat %0d", od, lat, LAT);
        end
        idle(4);
        send_one(8'b10000001, 4'd8, 3'd1, 1'b1, od, lat);
        checks++;
        if (lat != LAT || od !== 8'b00000011) begin
            errors++;
            $display("FAIL z8_left1 got %b lat %0d want 00000011 lat %0d", od, lat, LAT);
        end
        idle(4);
        send_one(8'b00000001, 4'd6, 3'd0, 1'b1, od, lat);
        checks++;
        if (lat != LAT || od !== 8'b00000001) begin
            errors++;
            $display("FAIL z6_left0 got %b lat %0d want 00000001 lat %0d", od, lat, LAT);
        end
        idle(4);
        send_one(8'b11111110, 4'd1, 3'd0, 1'b0, od, lat);
        checks++;
        if (lat != LAT || od !== 8'b00000000) begin
            errors++;
            $display("FAIL z1_pass got %b lat %0d want 00000000 lat %0d", od, lat, LAT);
        end
    endtask

    // Streams every pattern/shift/direction for z in {1,3,5,8}. With
    // rnd=0 out_ready stays high and the output must have no gaps; with
    // rnd=1 out_ready toggles and a stalled output must hold.
    task automatic test_stream(input bit rnd);
        vec_t       stim[$];
        logic [7:0] expq[$];
        vec_t       v;
        logic [7:0] expv;
        logic [7:0] held;
        logic       hold;
        int         zs[4];
        int         n;
        int         idx;
        int         nout;
        int         gaps;
        int         cyc;
        zs = '{1, 3, 5, 8};
        for (int zi = 0; zi < 4; zi++) begin
            for (int dr = 0; dr < 2; dr++) begin
                for (int s = 0; s < zs[zi]; s++) begin
                    for (int p = 0; p < (1 << zs[zi]); p++) begin
                        v.d  = 8'(p) | 8'($urandom() << zs[zi]);
                        v.z  = 4'(zs[zi]);
                        v.s  = 3'(s);
                        v.dr = 1'(dr);
                        stim.push_back(v);
                    end
                end
            end
        end
        n    = stim.size();
        idx  = 0;
        nout = 0;
        gaps = 0;
        cyc  = 0;
        hold = 1'b0;
        held = '0;
        idle(4);
        while (nout < n && cyc < n * 6 + 200) begin
            @(negedge CLK);
            cyc++;
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b d=%b want v=1 d=%b", out_valid, out_data, held);
                end
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra got %b want no output", out_data);
                end else begin
                    expv = expq.pop_front();
                    if (out_data !== expv) begin
                        errors++;
                        $display("FAIL stream_data idx %0d got %b want %b", nout, out_data, expv);
                    end
                end
                nout++;
            end else if (!rnd && nout > 0 && !out_valid) begin
                gaps++;
            end
            hold = out_valid && !out_ready;
            held = out_data;
            if (idx < n) begin
                in_valid  = 1'b1;
                in_data   = stim[idx].d;
                z_size    = stim[idx].z;
                shift_val = stim[idx].s;
                dir       = stim[idx].dr;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                expq.push_back(ref_rot(stim[idx].d, int'(stim[idx].z),
                                       int'(stim[idx].s), stim[idx].dr));
                idx++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (nout != n) begin
            errors++;
            $display("FAIL stream_count rnd=%0d got %0d want %0d", rnd, nout, n);
        end
        if (!rnd) begin
            checks++;
            if (gaps != 0) begin
                errors++;
                $display("FAIL stream_gaps got %0d want 0", gaps);
            end
        end
        idle(6);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_dup got out_valid %b want 0", out_valid);
        end
    endtask

    task automatic test_stall_reset;
        logic [7:0] w[3];
        logic [7:0] first;
        int         quiet;
        w = '{8'h3C, 8'h96, 8'hE1};
        first = ref_rot(w[0], 8, 1, 1'b0);
        idle(6);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_data   = w[i];
            z_size    = 4'd8;
            shift_val = 3'(i + 1);
            dir       = 1'b0;
            @(posedge CLK);
            @(negedge CLK);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== first) begin
                errors++;
                $display("FAIL stall_fill cyc %0d got rdy=%b v=%b d=%b want rdy=0 v=1 d=%b",
                         c, in_ready, out_valid, out_data, first);
            end
            @(negedge CLK);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got v=%b d=%h want v=0 d=00", out_valid, out_data);
        end
        @(negedge CLK);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        quiet = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (out_valid) quiet++;
        end
        checks++;
        if (quiet != 0) begin
            errors++;
            $display("FAIL reset_flush got %0d outputs want 0", quiet);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready2 got %b want 1", in_ready);
        end
    endtask

`ifdef QCS_RANGE_CHECK_EN
    task automatic test_range;
        logic [7:0] od;
        int         lat;
        idle(4);
        send_one(8'hA5, 4'd9, 3'd0, 1'b0, od, lat);
        checks++;
        if (lat != LAT || err !== 1'b1 || od !== 8'hA5) begin
            errors++;
            $display("FAIL range_z9 got err=%b d=%h lat %0d want err=1 d=a5", err, od, lat);
        end
        idle(4);
        send_one(8'hA5, 4'd4, 3'd4, 1'b0, od, lat);
        checks++;
        if (lat != LAT || err !== 1'b1 || od !== 8'h05) begin
            errors++;
            $display("FAIL range_s4 got err=%b d=%h lat %0d want err=1 d=05", err, od, lat);
        end
        idle(4);
        send_one(8'hA5, 4'd4, 3'd3, 1'b0, od, lat);
        checks++;
        if (lat != LAT || err !== 1'b0 || od !== 8'h0A) begin
            errors++;
            $display("FAIL range_ok got err=%b d=%h lat %0d want err=0 d=0a", err, od, lat);
        end
        idle(4);
        send_one(8'hA5, 4'd0, 3'd0, 1'b0, od, lat);
        checks++;
        if (lat != LAT || err !== 1'b1 || od !== 8'h00) begin
            errors++;
            $display("FAIL range_z0 got err=%b d=%h lat %0d want err=1 d=00", err, od, lat);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_stream(1'b0);
        test_stream(1'b1);
        test_stall_reset();
`ifdef QCS_RANGE_CHECK_EN
        test_range();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
